sap_ram_responder: RTL and testbench
====================================

// Module: sap_ram_responder
// PURPOSE
//  Memory-side responder for the PC -> MAR address path: the RAM that answers the address latched by the MAR.
//  In RUN it returns mem[addr_in] to the W-bus on a read request (ce). In PROG it accepts a byte stream over a
//  valid/ready handshake and writes it to sequential addresses from 0. This is the load path for a program.
//  Sits between the MAR output (to_RAM) and the W-bus/instruction register.
// PARAMETERS
//  ADDR_W   8   address width; must match MAR output width; DEPTH = 2**ADDR_W words
//  DATA_W   8   word width; must match W-bus width
// PORTS
//  clk        in   1       system clock; all state updates on posedge
//  reset      in   1       synchronous, active-high reset
//  addr_in    in   ADDR_W  read address from MAR (to_RAM)
//  ce         in   1       read request / chip enable, active-high
//  prog       in   1       program-mode request, active-high
//  wr_valid   in   1       wr_data valid (PROG handshake)
//  wr_data    in   DATA_W  byte to store at prog_addr
//  wr_ready   out  1       responder accepts a write this cycle
//  prog_addr  out  ADDR_W  next address to be written in PROG
//  prog_done  out  1       1-cycle pulse: last address (DEPTH-1) has been written
//  rd_data    out  DATA_W  registered read data
//  rd_valid   out  1       rd_data is valid for the current ce request
//  bus_en     out  1       drive W-bus; equals rd_valid
// BEHAVIOUR
//  Reset (sync, highest priority): state=IDLE. rd_data=0, rd_valid=0, bus_en=0, wr_ready=0, prog_addr=0,
//   prog_done=0. Memory contents are NOT cleared. Reset mid-PROG or mid-READ aborts immediately.
//  FSM states: IDLE, PROG, READ. All outputs are registered. wr_ready=1 exactly while state==PROG.
//  IDLE: prog=1 -> PROG (prog_addr<=0). Else ce=1 -> READ, with rd_data<=mem[addr_in] and
//   rd_valid<=1, bus_en<=1 on the same edge. This gives 1-cycle latency. prog has priority over ce.
//  READ: while ce=1 and prog=0, rd_data<=mem[addr_in] every edge, so data tracks addr_in one cycle later.
//   ce=0 -> IDLE with rd_valid<=0 and bus_en<=0; rd_data holds its last value.
//   prog=1 -> PROG with rd_valid<=0, bus_en<=0, and prog_addr<=0.
//  PROG: a transfer occurs on an edge with wr_valid=1 and wr_ready=1. It writes mem[prog_addr]<=wr_data
//   and increments prog_addr. Writing address DEPTH-1 sets prog_done<=1 for one cycle, wraps prog_addr to 0,
//   and moves the FSM to IDLE. wr_ready is therefore 0 on the next cycle.
//   prog=0 before completion -> IDLE; prog_addr holds and prog_done stays 0. Re-entering PROG restarts at 0.
//   ce is ignored in PROG. wr_valid is ignored outside PROG, with no write and no address change.
//  Widths: prog_addr increments modulo 2**ADDR_W. addr_in is used at full width, so no out-of-range case exists.
//  Read and write never occur on the same edge because the modes are exclusive.
// STRUCTURE
//  sap_pkg: state enum {IDLE, PROG, READ}; default ADDR_W/DATA_W localparams shared with PC and MAR.
//  Sub-module sap_ram_array: DEPTH x DATA_W array with sync write (we, waddr, wdata) and sync read
//   (raddr, rdata). The responder holds the FSM, prog_addr counter, and output registers.
// TESTING (bench uses ADDR_W=4, DEPTH=16)
//  1 Reset: hold reset for 2 cycles -> every output is 0 on the first edge; wr_valid=1 in IDLE -> no write,
//    prog_addr=0.
//  2 Program: prog=1, then 16 transfers with wr_data=8'hA0+i -> prog_done=1 only on the edge of the 16th
//    write; prog_addr=0, wr_ready=0, state IDLE on the following cycle.
//  3 Read: addr_in=4'h5, ce=1 for one cycle -> next edge rd_data=8'hA5, rd_valid=1, bus_en=1;
//    ce=0 -> next edge rd_valid=0, bus_en=0, rd_data still 8'hA5.
//  4 Tracking: ce held high, addr_in 3->4 -> rd_data goes 8'hA3 then 8'hA4, one cycle after each address.
//  5 Priority: prog=1 and ce=1 together in IDLE -> PROG entered, rd_valid=0, wr_ready=1.
//    With prog=1 during READ -> rd_valid drops on the same edge.
//  6 Abort: write 3 bytes (8'h11, 8'h22, 8'h33), then reset=1 -> prog_addr=0, wr_ready=0.
//    Reading addresses 0..2 returns 8'h11, 8'h22, 8'h33 (memory is not cleared).

Source files
------------

// File: rtl/sap_ram_responder_pkg.sv
// Shared types and default widths for the SAP RAM responder and its neighbours (PC, MAR).
// Pure declarations; no logic, no latency, no flow control.
package sap_ram_responder_pkg;

   localparam int SAP_ADDR_W = 8;
   localparam int SAP_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PROG = 2'd1,
      READ = 2'd2
   } state_e;

endpackage

// File: rtl/sap_ram_responder_if.sv
// Bundle of the MAR read path, the program-load stream and the W-bus read return.
// Wires only; the responder owns all timing, and wr_ready carries the write backpressure.
interface sap_ram_responder_if
   import sap_ram_responder_pkg::*;
#(
   parameter int ADDR_W = SAP_ADDR_W,
   parameter int DATA_W = SAP_DATA_W
);
   logic [ADDR_W-1:0] addr_in;
   logic              ce;
   logic              prog;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic [ADDR_W-1:0] prog_addr;
   logic              prog_done;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              bus_en;

   modport master (
      output addr_in, ce, prog, wr_valid, wr_data,
      input  wr_ready, prog_addr, prog_done, rd_data, rd_valid, bus_en
   );

   modport slave (
      input  addr_in, ce, prog, wr_valid, wr_data,
      output wr_ready, prog_addr, prog_done, rd_data, rd_valid, bus_en
   );
endinterface

// File: rtl/sap_ram_responder_array.sv
// DEPTH x DATA_W storage with synchronous write and enabled, resettable synchronous read.
// Latency: 1 cycle read; the write lands on the edge. No backpressure; rdata holds while re is low.
module sap_ram_responder_array
   import sap_ram_responder_pkg::*;
#(
   parameter int ADDR_W = SAP_ADDR_W,
   parameter int DATA_W = SAP_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   localparam int DEPTH = 1 << ADDR_W;

   // Storage has no reset so a program survives a reset of the control path.
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/sap_ram_responder.sv
// RAM responder: returns mem[addr_in] to the W-bus in RUN, loads a sequential byte stream in PROG.
// Latency: 1 cycle from ce to rd_data/rd_valid. Backpressure: wr_ready is high only while in PROG.
module sap_ram_responder
   import sap_ram_responder_pkg::*;
#(
   parameter int ADDR_W = SAP_ADDR_W,
   parameter int DATA_W = SAP_DATA_W
) (
   input  logic                   clk,
   input  logic                   reset,
   sap_ram_responder_if.slave     bus
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
   logic              prog_done_q, prog_done_d;
   logic              rd_valid_q, rd_valid_d;
   logic              bus_en_q, bus_en_d;
   logic              wr_ready_q, wr_ready_d;
   logic              we;
   logic              re;
   logic [DATA_W-1:0] rdata;

   always_comb begin
      state_d     = state_q;
      prog_addr_d = prog_addr_q;
      prog_done_d = 1'b0;
      rd_valid_d  = 1'b0;
      we          = 1'b0;
      re          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.prog) begin
               state_d     = PROG;
               prog_addr_d = '0;
            end else if (bus.ce) begin
               state_d    = READ;
               rd_valid_d = 1'b1;
               re         = 1'b1;
            end
         end
         READ: begin
            if (bus.prog) begin
               state_d     = PROG;
               prog_addr_d = '0;
            end else if (bus.ce) begin
               rd_valid_d = 1'b1;
               re         = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         PROG: begin
            // Dropping prog abandons the load; a write offered on that same edge is not taken.
            if (!bus.prog) begin
               state_d = IDLE;
            end else if (bus.wr_valid && wr_ready_q) begin
               we          = 1'b1;
               prog_addr_d = prog_addr_q + 1'b1;
               if (&prog_addr_q) begin
                  prog_done_d = 1'b1;
                  state_d     = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      bus_en_d   = rd_valid_d;
      wr_ready_d = (state_d == PROG);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         prog_addr_q <= '0;
         prog_done_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         bus_en_q    <= 1'b0;
         wr_ready_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         prog_addr_q <= prog_addr_d;
         prog_done_q <= prog_done_d;
         rd_valid_q  <= rd_valid_d;
         bus_en_q    <= bus_en_d;
         wr_ready_q  <= wr_ready_d;
      end
   end

   sap_ram_responder_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (we && !reset),
      .waddr (prog_addr_q),
      .wdata (bus.wr_data),
      .re    (re),
      .raddr (bus.addr_in),
      .rdata (rdata)
   );

   assign bus.wr_ready  = wr_ready_q;
   assign bus.prog_addr = prog_addr_q;
   assign bus.prog_done = prog_done_q;
   assign bus.rd_data   = rdata;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.bus_en    = bus_en_q;
endmodule

// File: tb/tb_sap_ram_responder.sv
// Directed bench for sap_ram_responder with a 16-word memory.
module tb_sap_ram_responder;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   sap_ram_responder_if #(.ADDR_W(4), .DATA_W(8)) bus ();

   sap_ram_responder #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.addr_in  = '0;
      bus.ce       = 1'b0;
      bus.prog     = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hFF;
      step();
      checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", bus.rd_data); end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
      checks++; if (bus.bus_en !== 1'b0) begin errors++; $display("FAIL reset_bus_en got %b exp 0", bus.bus_en); end
      checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b exp 0", bus.wr_ready); end
      checks++; if (bus.prog_addr !== 4'h0) begin errors++; $display("FAIL reset_prog_addr got %h exp 0", bus.prog_addr); end
      checks++; if (bus.prog_done !== 1'b0) begin errors++; $display("FAIL reset_prog_done got %b exp 0", bus.prog_done); end
      step();
      reset = 1'b0;
      step();
      step();
      checks++; if (bus.prog_addr !== 4'h0) begin errors++; $display("FAIL idle_wr_valid_prog_addr got %h exp 0", bus.prog_addr); end
      checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL idle_wr_valid_wr_ready got %b exp 0", bus.wr_ready); end
      idle_inputs();
   endtask

   task automatic test_program();
      bus.prog = 1'b1;
      step();
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL prog_enter_wr_ready got %b exp 1", bus.wr_ready); end
      for (int i = 0; i < 16; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = 8'hA0 + 8'(i);
         step();
         checks++;
         if (bus.prog_done !== (i == 15)) begin
            errors++; $display("FAIL prog_done_%0d got %b exp %b", i, bus.prog_done, (i == 15));
         end
         checks++;
         if (bus.prog_addr !== 4'((i + 1) % 16)) begin
            errors++; $display("FAIL prog_addr_%0d got %h exp %h", i, bus.prog_addr, (i + 1) % 16);
         end
         checks++;
         if (bus.wr_ready !== (i != 15)) begin
            errors++; $display("FAIL prog_wr_ready_%0d got %b exp %b", i, bus.wr_ready, (i != 15));
         end
      end
      idle_inputs();
      step();
      checks++; if (bus.prog_done !== 1'b0) begin errors++; $display("FAIL prog_done_pulse got %b exp 0", bus.prog_done); end
      checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL prog_after_wr_ready got %b exp 0", bus.wr_ready); end
      checks++; if (bus.prog_addr !== 4'h0) begin errors++; $display("FAIL prog_after_addr got %h exp 0", bus.prog_addr); end
   endtask

   task automatic test_read();
      bus.addr_in = 4'h5;
      bus.ce      = 1'b1;
      step();
      checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL read_data got %h exp a5", bus.rd_data); end
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL read_valid got %b exp 1", bus.rd_valid); end
      checks++; if (bus.bus_en !== 1'b1) begin errors++; $display("FAIL read_bus_en got %b exp 1", bus.bus_en); end
      bus.ce       = 1'b0;
      bus.wr_valid = 1'b1;
      step();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL read_end_valid got %b exp 0", bus.rd_valid); end
      checks++; if (bus.bus_en !== 1'b0) begin errors++; $display("FAIL read_end_bus_en got %b exp 0", bus.bus_en); end
      checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL read_hold_data got %h exp a5", bus.rd_data); end
      checks++; if (bus.prog_addr !== 4'h0) begin errors++; $display("FAIL read_wr_valid_addr got %h exp 0", bus.prog_addr); end
      idle_inputs();
   endtask

   task automatic test_tracking();
      bus.ce      = 1'b1;
      bus.addr_in = 4'h3;
      step();
      checks++; if (bus.rd_data !== 8'hA3) begin errors++; $display("FAIL track_a3 got %h exp a3", bus.rd_data); end
      bus.addr_in = 4'h4;
      step();
      checks++; if (bus.rd_data !== 8'hA4) begin errors++; $display("FAIL track_a4 got %h exp a4", bus.rd_data); end
      checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL track_valid got %b exp 1", bus.rd_valid); end
      bus.addr_in = 4'hF;
      step();
      checks++; if (bus.rd_data !== 8'hAF) begin errors++; $display("FAIL track_af got %h exp af", bus.rd_data); end
      idle_inputs();
      step();
   endtask

   task automatic test_priority();
      bus.prog = 1'b1;
      bus.ce   = 1'b1;
      step();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL prio_idle_valid got %b exp 0", bus.rd_valid); end
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL prio_idle_wr_ready got %b exp 1", bus.wr_ready); end
      idle_inputs();
      step();
      bus.ce      = 1'b1;
      bus.addr_in = 4'h7;
      step();
      checks++; if (bus.rd_data !== 8'hA7) begin errors++; $display("FAIL prio_read_data got %h exp a7", bus.rd_data); end
      bus.prog = 1'b1;
      step();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL prio_read_valid got %b exp 0", bus.rd_valid); end
      checks++; if (bus.bus_en !== 1'b0) begin errors++; $display("FAIL prio_read_bus_en got %b exp 0", bus.bus_en); end
      checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL prio_read_wr_ready got %b exp 1", bus.wr_ready); end
      idle_inputs();
      step();
      checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL prio_exit_wr_ready got %b exp 0", bus.wr_ready); end
   endtask

   task automatic test_abort();
      logic [7:0] bytes [3];
      bytes[0] = 8'h11;
      bytes[1] = 8'h22;
      bytes[2] = 8'h33;
      bus.prog = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_data  = bytes[i];
         step();
      end
      checks++; if (bus.prog_addr !== 4'h3) begin errors++; $display("FAIL abort_pre_addr got %h exp 3", bus.prog_addr); end
      bus.wr_valid = 1'b0;
      reset = 1'b1;
      step();
      checks++; if (bus.prog_addr !== 4'h0) begin errors++; $display("FAIL abort_prog_addr got %h exp 0", bus.prog_addr); end
      checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL abort_wr_ready got %b exp 0", bus.wr_ready); end
      reset = 1'b0;
      idle_inputs();
      step();
      bus.ce = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.addr_in = 4'(i);
         step();
         checks++;
         if (bus.rd_data !== bytes[i]) begin
            errors++; $display("FAIL abort_read_%0d got %h exp %h", i, bus.rd_data, bytes[i]);
         end
      end
      bus.addr_in = 4'h3;
      step();
      checks++; if (bus.rd_data !== 8'hA3) begin errors++; $display("FAIL abort_read_3 got %h exp a3", bus.rd_data); end
      idle_inputs();
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      idle_inputs();
      test_reset();
      test_program();
      test_read();
      test_tracking();
      test_priority();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
